// File: rtl/freq_counter_multi_if.sv
// Control/result bundle for freq_counter_multi.
//   master: ena, gate_cycles, continuous, start  -> ; <- count_out, ovf_out, done, busy
//   slave : the counter core (mirror directions)
interface freq_counter_multi_if #(
  parameter int CHANNELS    = 2,
  parameter int COUNT_WIDTH = 16,
  parameter int GATE_WIDTH  = 24
);
  logic                            ena;
  logic [GATE_WIDTH-1:0]           gate_cycles;
  logic                            continuous;
  logic                            start;
  logic [CHANNELS*COUNT_WIDTH-1:0] count_out;
  logic [CHANNELS-1:0]             ovf_out;
  logic                            done;
  logic                            busy;

  modport master (
    output ena, gate_cycles, continuous, start,
    input  count_out, ovf_out, done, busy
  );

  modport slave (
    input  ena, gate_cycles, continuous, start,
    output count_out, ovf_out, done, busy
  );
endinterface

// File: rtl/freq_counter_multi.sv
// Multi-channel gated frequency counter.
// Counts rising edges on CHANNELS asynchronous inputs over a gate window of
// max(gate_cycles,1) clk cycles, then latches per-channel counts and overflow
// flags and pulses done. Single-shot (start) or free-running (continuous).
//   clk, rst_n : clock, async active-low reset
//   sig_in     : asynchronous inputs to measure, one bit per channel
//   bus        : slave side of freq_counter_multi_if (control in, results out)

// Per-channel input path: synchroniser, rising-edge detect, saturating counter.
// cnt_nxt/ovf_nxt are exposed so the top can latch the final gate-cycle value
// in the same edge that leaves GATE.
module fcm_lane #(
  parameter int COUNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sig,
  input  logic                   clr,
  input  logic                   cnt_en,
  output logic [COUNT_WIDTH-1:0] cnt_nxt,
  output logic                   ovf_nxt
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   rise;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   ovf;

  assign rise = sync[SYNC_STAGES-1] & ~prev;

  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (clr) begin
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (cnt_en && rise) begin
      if (&cnt) ovf_nxt = 1'b1;             // saturate, flag the lost edge
      else      cnt_nxt = cnt + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig};
      prev <= sync[SYNC_STAGES-1];
      cnt  <= cnt_nxt;
      ovf  <= ovf_nxt;
    end
  end
endmodule

module freq_counter_multi #(
  parameter int CHANNELS    = 2,
  parameter int COUNT_WIDTH = 16,
  parameter int GATE_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] sig_in,
  freq_counter_multi_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;

  state_t                                 state;
  logic [GATE_WIDTH-1:0]                  timer;
  logic [GATE_WIDTH-1:0]                  timer_load;
  logic                                   gate_start;
  logic                                   cnt_en;
  logic [CHANNELS-1:0][COUNT_WIDTH-1:0]   cnt_nxt;
  logic [CHANNELS-1:0]                    ovf_nxt;
  logic [CHANNELS-1:0][COUNT_WIDTH-1:0]   count_q;
  logic [CHANNELS-1:0]                    ovf_q;
  logic                                   done_q;
  logic                                   busy_q;

  // gate_cycles = 0 behaves as a one-cycle gate
  assign timer_load = (bus.gate_cycles == '0) ? '0 : bus.gate_cycles - GATE_WIDTH'(1);

  // A gate opens from IDLE on start/continuous, or back-to-back from LATCH
  // when free-running. Also clears the lane counters.
  assign gate_start = bus.ena && (((state == IDLE) && (bus.start || bus.continuous)) ||
                                  ((state == LATCH) && bus.continuous));
  assign cnt_en     = (state == GATE);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    fcm_lane #(.COUNT_WIDTH(COUNT_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .sig     (sig_in[i]),
      .clr     (gate_start),
      .cnt_en  (cnt_en),
      .cnt_nxt (cnt_nxt[i]),
      .ovf_nxt (ovf_nxt[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      count_q <= '0;
      ovf_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (gate_start) begin
          state  <= GATE;
          timer  <= timer_load;
          busy_q <= 1'b1;
        end
        GATE: if (!bus.ena) begin
          state  <= IDLE;                   // abort: results untouched
          busy_q <= 1'b0;
        end else begin
          timer <= timer - GATE_WIDTH'(1);
          if (timer == '0) begin
            // last gate cycle's edges are in cnt_nxt, so latch them now
            state   <= LATCH;
            count_q <= cnt_nxt;
            ovf_q   <= ovf_nxt;
            done_q  <= 1'b1;
          end
        end
        LATCH: if (gate_start) begin
          state <= GATE;
          timer <= timer_load;
        end else begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count_out = count_q;
  assign bus.ovf_out   = ovf_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_freq_counter_multi.sv
// Self-checking bench for freq_counter_multi: table of gate runs with hand
// expectations, randomized runs checked against an edge-counting model over
// recorded input samples, plus continuous / abort / busy-start / reset sequences.
module tb_freq_counter_multi;
  localparam int CH = 2, CW = 8, GW = 12, SS = 2, MAXC = 40000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [CH-1:0] sig_in = '0;

  freq_counter_multi_if #(.CHANNELS(CH), .COUNT_WIDTH(CW), .GATE_WIDTH(GW)) bus();

  freq_counter_multi #(.CHANNELS(CH), .COUNT_WIDTH(CW), .GATE_WIDTH(GW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .bus(bus)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int cyc = 0;
  bit [CH-1:0] samp [MAXC];
  int per [CH];   // -1 random, 0 hold high, else square-wave period
  int ph  [CH];
  int exp_c [CH];
  bit [CH-1:0] exp_o;

  // record what the DUT samples at each rising edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < MAXC) samp[cyc] = sig_in;
  end

  always @(negedge clk)
    for (int c = 0; c < CH; c++) begin
      if (per[c] < 0)       sig_in[c] = 1'($urandom % 2);
      else if (per[c] == 0) sig_in[c] = 1'b1;
      else begin
        ph[c] = (ph[c] + 1) % per[c];
        sig_in[c] = (ph[c] < per[c] / 2);
      end
    end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input longint act, input longint expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // rising edges seen on pin samples whose pulse falls inside the gate that
  // opened at posedge g and lasts n cycles, saturated to CW bits
  task automatic model(input int g, input int n, input int c, output int cnt, output bit ovf);
    int raw = 0;
    for (int i = g - SS + 1; i <= g + n - SS; i++)
      if (samp[i][c] && !samp[i-1][c]) raw++;
    cnt = (raw > (1 << CW) - 1) ? (1 << CW) - 1 : raw;
    ovf = (raw > (1 << CW) - 1);
  endtask

  task automatic set_per(input int p0, input int p1);
    @(negedge clk);
    per[0] = p0; per[1] = p1;
    repeat (20) @(negedge clk);
  endtask

  task automatic run_shot(input int gc, output int g, output int n);
    @(negedge clk);
    bus.gate_cycles = GW'(gc);
    bus.start = 1'b1;
    g = cyc + 1;
    n = (gc == 0) ? 1 : gc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int expc, input string nm);
    int seen = -1;
    int lim = expc - cyc + 20;
    for (int k = 0; k < lim; k++) begin
      if (bus.done) begin seen = cyc; break; end
      @(negedge clk);
    end
    check(nm, seen, expc);
  endtask

  task automatic check_result(input int g, input int n, input int t0, input int t1,
                              input int tovf, input string tag);
    int m; bit o; bit [CH-1:0] mo;
    int tv [CH];
    tv[0] = t0; tv[1] = t1;
    for (int c = 0; c < CH; c++) begin
      model(g, n, c, m, o);
      mo[c] = o;
      exp_c[c] = m;
      check($sformatf("%s model ch%0d", tag, c), bus.count_out[c*CW +: CW], m);
      if (tv[c] >= 0) check($sformatf("%s table ch%0d", tag, c), bus.count_out[c*CW +: CW], tv[c]);
    end
    exp_o = mo;
    check($sformatf("%s model ovf", tag), bus.ovf_out, mo);
    if (tovf >= 0) check($sformatf("%s table ovf", tag), bus.ovf_out, tovf);
  endtask

  typedef struct { int gc; int p0; int p1; int e0; int e1; int eovf; } vec_t;
  vec_t tbl [8];

  initial begin
    int g, n, nd;
    int econt [3];
    tbl[0] = '{100, 10,  4,  10,  25,  0};
    tbl[1] = '{600,  2,  0, 255,   0,  1};
    tbl[2] = '{100,  2, -1,  50,  -1,  0};
    tbl[3] = '{  0,  0,  0,   0,   0,  0};
    tbl[4] = '{510,  2,  0, 255,   0,  0};
    tbl[5] = '{512,  2,  4, 255, 128,  1};
    tbl[6] = '{  1,  2,  2,  -1,  -1, -1};
    tbl[7] = '{ 37, -1, -1,  -1,  -1, -1};
    econt = '{10, 10, 4};
    per[0] = -1; per[1] = -1; ph[0] = 0; ph[1] = 0;
    bus.ena = 1'b1; bus.start = 1'b0; bus.continuous = 1'b0; bus.gate_cycles = '0;

    // reset with inputs toggling
    repeat (6) @(negedge clk);
    check("rst count", bus.count_out, 0);
    check("rst ovf", bus.ovf_out, 0);
    check("rst done", bus.done, 0);
    check("rst busy", bus.busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post-rst busy", bus.busy, 0);
    check("post-rst count", bus.count_out, 0);

    // table-driven single-shot runs
    foreach (tbl[v]) begin
      set_per(tbl[v].p0, tbl[v].p1);
      run_shot(tbl[v].gc, g, n);
      check($sformatf("v%0d busy", v), bus.busy, 1);
      wait_done(g + n, $sformatf("v%0d done cycle", v));
      check_result(g, n, tbl[v].e0, tbl[v].e1, tbl[v].eovf, $sformatf("v%0d", v));
      @(negedge clk);
      check($sformatf("v%0d done width", v), bus.done, 0);
      @(negedge clk);
      check($sformatf("v%0d idle busy", v), bus.busy, 0);
    end

    // randomized runs against the model
    for (int r = 0; r < 8; r++) begin
      set_per((r % 3 == 0) ? -1 : int'($urandom_range(2, 9)), -1);
      run_shot(int'($urandom_range(0, 80)), g, n);
      wait_done(g + n, $sformatf("r%0d done cycle", r));
      check_result(g, n, -1, -1, -1, $sformatf("r%0d", r));
    end

    // continuous: gate length change mid-gate applies to the next gate only,
    // dropping continuous lets the current gate finish
    set_per(5, -1);
    @(negedge clk);
    bus.gate_cycles = GW'(50);
    bus.continuous = 1'b1;
    g = cyc + 1; n = 50;
    for (int r = 0; r < 3; r++) begin
      wait_done(g + n, $sformatf("cont%0d done cycle", r));
      check_result(g, n, econt[r], -1, 0, $sformatf("cont%0d", r));
      g = g + n + 1;
      n = (r == 0) ? 50 : 20;
      if (r < 2) begin
        repeat (3) @(negedge clk);
        if (r == 0) bus.gate_cycles = GW'(20);
        else        bus.continuous = 1'b0;
      end
    end
    @(negedge clk);
    check("cont stop busy", bus.busy, 0);
    nd = 0;
    repeat (60) begin @(negedge clk); if (bus.done) nd++; end
    check("cont stop dones", nd, 0);

    // abort via ena in gate cycle 30
    set_per(3, 7);
    run_shot(100, g, n);
    repeat (29) @(negedge clk);
    bus.ena = 1'b0;
    @(negedge clk);
    check("abort busy", bus.busy, 0);
    nd = 0;
    repeat (120) begin @(negedge clk); if (bus.done) nd++; end
    check("abort dones", nd, 0);
    for (int c = 0; c < CH; c++)
      check($sformatf("abort hold ch%0d", c), bus.count_out[c*CW +: CW], exp_c[c]);
    check("abort hold ovf", bus.ovf_out, exp_o);
    bus.ena = 1'b1;

    // start pulses while busy (mid-gate and in the latch cycle) are ignored
    run_shot(40, g, n);
    nd = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.done) nd++;
      bus.start = (k == 10 || k == 20 || k == 40);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("busy start dones", nd, 1);
    check("busy start idle", bus.busy, 0);

    // async reset mid-gate clears outputs immediately
    run_shot(200, g, n);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", bus.busy, 0);
    check("async rst count", bus.count_out, 0);
    check("async rst ovf", bus.ovf_out, 0);
    check("async rst done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("after async rst busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
